// File: rtl/network_sequencer.sv
// Word-serial front end for the NETWORK datapath: gathers an input vector,
// fires one inference, waits under a timeout and streams the result back.
module network_sequencer #(
  parameter int NUM_INPUTS     = 4,
  parameter int NUM_OUTPUTS    = 2,
  parameter int WORD_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [WORD_WIDTH-1:0]             S_DATA,
  input  logic                              S_VALID,
  output logic                              S_READY,
  output logic [NUM_INPUTS*WORD_WIDTH-1:0]  NET_VALUES_IN,
  output logic                              NET_VALID_IN,
  input  logic [NUM_OUTPUTS*WORD_WIDTH-1:0] NET_VALUES_OUT,
  input  logic                              NET_VALID_OUT,
  output logic [WORD_WIDTH-1:0]             M_DATA,
  output logic                              M_VALID,
  input  logic                              M_READY,
  output logic                              M_LAST,
  output logic                              BUSY,
  output logic                              ERR,
  input  logic                              ERR_CLR,
  output logic [15:0]                       INFER_COUNT
);

  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int OW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [IW-1:0] IN_LAST  = IW'(NUM_INPUTS - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(NUM_OUTPUTS - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_FIRE,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         in_cnt_q, in_cnt_d;
  logic [OW-1:0]         out_cnt_q, out_cnt_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [WORD_WIDTH-1:0] ibuf_q [NUM_INPUTS];
  logic [WORD_WIDTH-1:0] ibuf_d [NUM_INPUTS];
  logic [WORD_WIDTH-1:0] obuf_q [NUM_OUTPUTS];
  logic [WORD_WIDTH-1:0] obuf_d [NUM_OUTPUTS];
  logic                  err_q, err_d;
  logic                  s_ready_q, s_ready_d;
  logic [15:0]           cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    timer_d   = timer_q;
    ibuf_d    = ibuf_q;
    obuf_d    = obuf_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    if (ERR_CLR) err_d = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (S_VALID && s_ready_q) begin
          ibuf_d[in_cnt_q] = S_DATA;
          if (in_cnt_q == IN_LAST) begin
            in_cnt_d = '0;
            state_d  = ST_FIRE;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      ST_FIRE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A result in the final wait cycle beats the timeout
        if (NET_VALID_OUT) begin
          for (int i = 0; i < NUM_OUTPUTS; i++)
            obuf_d[i] = NET_VALUES_OUT[i*WORD_WIDTH +: WORD_WIDTH];
          cnt_d   = cnt_q + 16'd1;
          state_d = ST_DRAIN;
        end else if (timer_q == T_LAST) begin
          err_d   = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (M_READY) begin
          if (out_cnt_q == OUT_LAST) begin
            out_cnt_d = '0;
            state_d   = ST_LOAD;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
    // Registered so that S_READY is low while RST is held
    s_ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_LOAD;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      timer_q   <= '0;
      err_q     <= 1'b0;
      s_ready_q <= 1'b0;
      cnt_q     <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) ibuf_q[i] <= '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) obuf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      s_ready_q <= s_ready_d;
      cnt_q     <= cnt_d;
      ibuf_q    <= ibuf_d;
      obuf_q    <= obuf_d;
    end
  end

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_vin
    assign NET_VALUES_IN[g*WORD_WIDTH +: WORD_WIDTH] = ibuf_q[g];
  end

  assign S_READY      = s_ready_q;
  assign NET_VALID_IN = (state_q == ST_FIRE);
  assign BUSY         = (state_q != ST_LOAD);
  assign M_VALID      = (state_q == ST_DRAIN);
  assign M_DATA       = M_VALID ? obuf_q[out_cnt_q] : '0;
  assign M_LAST       = M_VALID && (out_cnt_q == OUT_LAST);
  assign ERR          = err_q;
  assign INFER_COUNT  = cnt_q;

endmodule
